bme_i2c_target: RTL and testbench

I2C target (responder) that emulates the BME280's register interface on the on-board bus, the counterpart to the ROM-driven I2C initiator sequence that talks to the sensor. It oversamples SCL/SDA in the system clock domain and decodes START, STOP, the address and R/W phases. It drives ACK and read data onto an open-drain SDA and exposes a simple byte-wide register port to a local register file. It is used as a bench/loopback sensor model and as a bring-up target on the same bus.

---
 rtl/bme_i2c_target.sv | 252 +++++++++++++++++++++++++
 tb/tb_bme_i2c_target.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bme_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : bme_i2c_target
// Purpose  : Oversampled I2C target exposing a BME280-style register port.
// Revision : 1.0  initial release
// ============================================================================
module bme_i2c_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h76,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [2:0] c_cnt_max = 3'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_BYTE  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_BYTE  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    logic [1:0] w_pad;
    logic [1:0] w_filt;

    assign w_pad = {scl_i, sda_i};

    // Index 1 is SCL, index 0 is SDA; both rest high like an idle bus.
    for (genvar gi = 0; gi < 2; gi++) begin : g_filter
        logic       r_meta;
        logic       r_sync;
        logic       r_lvl;
        logic [2:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_meta <= 1'b1;
                r_sync <= 1'b1;
                r_lvl  <= 1'b1;
                r_cnt  <= 3'd0;
            end else begin
                r_meta <= w_pad[gi];
                r_sync <= r_meta;
                if (r_sync == r_lvl) begin
                    r_cnt <= 3'd0;
                end else if (r_cnt == c_cnt_max) begin
                    r_lvl <= r_sync;
                    r_cnt <= 3'd0;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end

        assign w_filt[gi] = r_lvl;
    end

    state_t     r_state;
    logic       r_scl_d;
    logic       r_sda_d;
    logic [6:0] r_shift;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_ptr;
    logic [7:0] r_tx;
    logic       r_rw;
    logic       r_first;
    logic       r_cap;

    logic       w_scl;
    logic       w_sda;
    logic       w_rise;
    logic       w_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;
    logic       w_last_bit;
    logic       w_tx_bit;
    logic       w_match;

    assign w_scl      = w_filt[1];
    assign w_sda      = w_filt[0];
    assign w_rise     = w_scl & ~r_scl_d;
    assign w_fall     = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift, w_sda};
    assign w_last_bit = (r_bit_cnt == 4'd7);
    assign w_tx_bit   = r_tx[3'd7 - r_bit_cnt[2:0]];
    assign w_match    = (w_byte[7:1] == DEV_ADDR) && (w_byte[7:1] != 7'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_scl_d   <= 1'b1;
            r_sda_d   <= 1'b1;
            r_shift   <= 7'd0;
            r_bit_cnt <= 4'd0;
            r_ptr     <= 8'h00;
            r_tx      <= 8'h00;
            r_rw      <= 1'b0;
            r_first   <= 1'b0;
            r_cap     <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            // Register file answers one cycle after the strobe; latch it then.
            r_cap   <= reg_re;
            if (r_cap) begin
                r_tx  <= reg_rdata;
                r_ptr <= r_ptr + 8'd1;
            end

            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                sda_oe    <= 1'b0;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) begin
                                if (w_match) begin
                                    r_state <= S_ADDR_ACK;
                                    r_rw    <= w_byte[0];
                                    r_first <= ~w_byte[0];
                                    busy    <= 1'b1;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_rise) begin
                            r_bit_cnt <= 4'd9;
                            reg_re    <= r_rw;
                            reg_addr  <= r_ptr;
                        end else if (w_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                sda_oe <= 1'b1;
                            end else if (r_bit_cnt == 4'd9) begin
                                r_bit_cnt <= 4'd0;
                                if (r_rw) begin
                                    r_state <= S_RD_BYTE;
                                    sda_oe  <= ~r_tx[7];
                                end else begin
                                    r_state <= S_WR_BYTE;
                                    sda_oe  <= 1'b0;
                                end
                            end
                        end
                    end
                    S_WR_BYTE: begin
                        if (w_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) begin
                                r_state <= S_WR_ACK;
                                if (r_first) begin
                                    r_ptr   <= w_byte;
                                    r_first <= 1'b0;
                                end else begin
                                    reg_we    <= 1'b1;
                                    reg_addr  <= r_ptr;
                                    reg_wdata <= w_byte;
                                    r_ptr     <= r_ptr + 8'd1;
                                end
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (w_rise) begin
                            r_bit_cnt <= 4'd9;
                        end else if (w_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                sda_oe <= 1'b1;
                            end else if (r_bit_cnt == 4'd9) begin
                                r_state   <= S_WR_BYTE;
                                r_bit_cnt <= 4'd0;
                                sda_oe    <= 1'b0;
                            end
                        end
                    end
                    S_RD_BYTE: begin
                        if (w_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                r_state <= S_RD_ACK;
                            end else begin
                                sda_oe <= ~w_tx_bit;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_rise) begin
                            if (w_sda) begin
                                r_state <= S_IGNORE;
                            end else begin
                                reg_re    <= 1'b1;
                                reg_addr  <= r_ptr;
                                r_bit_cnt <= 4'd9;
                            end
                        end else if (w_fall && (r_bit_cnt == 4'd9)) begin
                            r_state   <= S_RD_BYTE;
                            r_bit_cnt <= 4'd0;
                            sda_oe    <= ~r_tx[7];
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        sda_oe  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bme_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_bme_i2c_target
// Purpose  : Bit-banged I2C initiator with a transaction-level register model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bme_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scl_m;
    logic       sda_m;
    logic       w_sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    always #5 clk = ~clk;

    assign w_sda_bus = sda_m & ~sda_oe;

    bme_i2c_target #(
        .DEV_ADDR  (7'h76),
        .FILTER_LEN(3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_i    (scl_m),
        .sda_i    (w_sda_bus),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy)
    );

    // Local register file with a registered read port
    logic [7:0] regs    [256];
    logic [7:0] ref_mem [256];
    logic       preload;
    logic [7:0] pl_idx;

    always @(posedge clk) begin
        if (preload)     regs[pl_idx]   <= ref_mem[pl_idx];
        else if (reg_we) regs[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= regs[reg_addr];
    end

    logic [15:0] we_q [$];
    logic [7:0]  re_q [$];
    int          both_cnt = 0;
    logic        oe_seen  = 1'b0;
    logic        busy_seen = 1'b0;

    always @(posedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
        if (reg_we && reg_re) both_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus primitives; every phase lasts Q clocks
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic m_rstart();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic m_bit(input logic b, output logic s);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q();
        s = w_sda_bus; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic m_write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            b[i] = s;
        end
        m_bit(nack, s);
    endtask

    // Transaction-level reference model
    logic [7:0]  ref_ptr = 8'h00;
    logic [15:0] exp_we [$];
    logic [7:0]  exp_re [$];
    logic [7:0]  wbuf [8];
    logic [7:0]  last_rd;

    task automatic write_body(input logic [6:0] a, input int n, input string tag);
        logic ack;
        logic match;
        match = (a == 7'h76);
        m_write_byte({a, 1'b0}, ack);
        check({tag, " addr ack"}, ack, !match);
        for (int k = 0; k < n; k++) begin
            m_write_byte(wbuf[k], ack);
            check({tag, " data ack"}, ack, !match);
            if (match) begin
                if (k == 0) begin
                    ref_ptr = wbuf[k];
                end else begin
                    exp_we.push_back({ref_ptr, wbuf[k]});
                    ref_mem[ref_ptr] = wbuf[k];
                    ref_ptr = ref_ptr + 8'd1;
                end
            end
        end
    endtask

    task automatic read_body(input logic [6:0] a, input int n, input string tag);
        logic       ack;
        logic [7:0] b;
        m_write_byte({a, 1'b1}, ack);
        check({tag, " addr ack"}, ack, !(a == 7'h76));
        if (a == 7'h76) begin
            for (int k = 0; k < n; k++) begin
                m_read_byte(k == n - 1, b);
                check({tag, " rdata"}, b, ref_mem[ref_ptr]);
                exp_re.push_back(ref_ptr);
                last_rd = b;
                ref_ptr = ref_ptr + 8'd1;
            end
        end
    endtask

    task automatic check_strobes(input string tag);
        check({tag, " we count"}, we_q.size(), exp_we.size());
        for (int i = 0; i < exp_we.size() && i < we_q.size(); i++)
            check({tag, " we"}, we_q[i], exp_we[i]);
        check({tag, " re count"}, re_q.size(), exp_re.size());
        for (int i = 0; i < exp_re.size() && i < re_q.size(); i++)
            check({tag, " re addr"}, re_q[i], exp_re[i]);
        we_q.delete(); re_q.delete(); exp_we.delete(); exp_re.delete();
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [6:0] a;
        int         n;
        int         kind;
        int         wait_cnt;
        logic [7:0] wrap_exp [3];
        wrap_exp = '{8'hFE, 8'hFF, 8'h00};

        reset_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; preload = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            pl_idx = 8'(i); preload = 1'b1;
            @(negedge clk);
        end
        preload = 1'b0;
        @(negedge clk);

        check("rst sda_oe", sda_oe, 0);
        check("rst reg_we", reg_we, 0);
        check("rst reg_re", reg_re, 0);
        check("rst reg_addr", reg_addr, 8'h00);
        check("rst reg_wdata", reg_wdata, 8'h00);
        check("rst busy", busy, 0);
        reset_n = 1'b1;
        wait_q();
        we_q.delete(); re_q.delete();

        // Write F4 <= 27
        m_start();
        wbuf[0] = 8'hF4; wbuf[1] = 8'h27;
        write_body(7'h76, 2, "wr");
        check("wr busy high", busy, 1);
        m_stop();
        check("wr busy low", busy, 0);
        check_strobes("wr");

        // Pointer continues at F5
        m_start();
        read_body(7'h76, 1, "wr-ptr");
        m_stop();
        check("wr-ptr F5", (re_q.size() > 0) ? re_q[0] : 8'hxx, 8'hF5);
        check_strobes("wr-ptr");

        // Combined read: D0 holds 0x60
        m_start();
        wbuf[0] = 8'hD0; wbuf[1] = 8'h60;
        write_body(7'h76, 2, "cr-setup");
        m_stop();
        check_strobes("cr-setup");
        m_start();
        wbuf[0] = 8'hD0;
        write_body(7'h76, 1, "cr-ptr");
        m_rstart();
        read_body(7'h76, 1, "cr");
        m_stop();
        check("cr data", last_rd, 8'h60);
        check_strobes("cr");

        // Burst read across the pointer wrap
        m_start();
        wbuf[0] = 8'hFE;
        write_body(7'h76, 1, "wrap-ptr");
        m_stop();
        check_strobes("wrap-ptr");
        m_start();
        read_body(7'h76, 3, "wrap");
        m_stop();
        for (int i = 0; i < 3; i++)
            check("wrap addr", (re_q.size() > i) ? re_q[i] : 8'hxx, wrap_exp[i]);
        check_strobes("wrap");

        // Foreign address is ignored
        oe_seen = 1'b0; busy_seen = 1'b0;
        m_start();
        wbuf[0] = 8'h55;
        write_body(7'h77, 1, "mis");
        m_stop();
        check("mis sda_oe", oe_seen, 0);
        check("mis busy", busy_seen, 0);
        check_strobes("mis");

        // 2-clk SDA dip while SCL high must not look like START
        busy_seen = 1'b0;
        wait_q();
        @(negedge clk); sda_m = 1'b0;
        repeat (2) @(negedge clk); sda_m = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch busy", busy, 0);
        scl_m = 1'b0; wait_q();
        m_write_byte(8'hEC, ack);
        check("glitch no ack", ack, 1);
        m_stop();
        check("glitch busy seen", busy_seen, 0);
        check_strobes("glitch");

        // Random traffic against the model
        for (int t = 0; t < 16; t++) begin
            a    = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'h76;
            n    = $urandom_range(1, 4);
            kind = $urandom_range(0, 2);
            for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
            m_start();
            if (kind == 0) begin
                write_body(a, n, "rnd-wr");
            end else if (kind == 1) begin
                read_body(a, n, "rnd-rd");
            end else begin
                write_body(7'h76, 1, "rnd-ptr");
                m_rstart();
                read_body(a, n, "rnd-cr");
            end
            m_stop();
            check_strobes("rnd");
        end

        // Reset while the target drives a 0 data bit
        m_start();
        wbuf[0] = 8'h10; wbuf[1] = 8'h00;
        write_body(7'h76, 2, "rm-setup");
        m_stop();
        check_strobes("rm-setup");
        m_start();
        wbuf[0] = 8'h10;
        write_body(7'h76, 1, "rm-ptr");
        m_rstart();
        m_write_byte(8'hED, ack);
        check("rm addr ack", ack, 0);
        wait_cnt = 0;
        while (!sda_oe && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("rm driving", sda_oe, 1);
        we_q.delete(); re_q.delete(); exp_we.delete(); exp_re.delete();
        reset_n = 1'b0;
        @(negedge clk);
        check("rm release", sda_oe, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ref_ptr = 8'h00;
        check("rm no strobes", we_q.size() + re_q.size(), 0);
        m_stop();
        m_start();
        read_body(7'h76, 1, "rm-rd0");
        m_stop();
        check("rm ptr zero", (re_q.size() > 0) ? re_q[0] : 8'hxx, 8'h00);
        check_strobes("rm-rd0");
        m_start();
        wbuf[0] = 8'hF4; wbuf[1] = 8'hAB;
        write_body(7'h76, 2, "rm-wr");
        m_stop();
        check_strobes("rm-wr");

        check("we/re exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
